// File: rtl/imm_rot_encoder.sv
// ---------------------------------------------------------------------------
// imm_rot_encoder
//
// Purpose:
//   Sequential encoder that turns a 32-bit constant into the ARM
//   data-processing immediate form {rotate[3:0], imm8[7:0]}. The encoded value
//   is imm8 rotated right by 2*rotate. This is the inverse of the val2
//   generator's immediate decode path.
//
//   The search tests TESTS_PER_CYCLE rotate candidates per clock. Candidate r
//   matches when rotl(value, 2r) fits in 8 bits. The smallest matching rotate
//   always wins, so the result is canonical.
//
// Configuration:
//   TESTS_PER_CYCLE : number of candidates tested per clock. Legal values are
//                     1, 2, 4, 8 and 16; any other value stops elaboration.
//   IMM_NEG_SEARCH_EN (macro) : when defined and all 16 plain candidates fail,
//                     a second pass searches ~value with the same rules.
//                     A hit from that pass sets neg=1. When undefined, neg
//                     is constant 0.
//
// Ports:
//   clk           in   1   clock, rising edge
//   rst           in   1   synchronous, active-high reset
//   in_valid      in   1   request strobe
//   in_ready      out  1   high only while idle
//   value         in   32  constant to encode, sampled on the accept edge
//   out_valid     out  1   result valid, held until accepted
//   out_ready     in   1   consumer accept
//   shift_operand out  12  {rot[3:0], imm8[7:0]}
//   ok            out  1   1 = encodable
//   neg           out  1   1 = result encodes ~value
// ---------------------------------------------------------------------------
module imm_rot_encoder #(
    parameter int TESTS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] shift_operand,
    output logic        ok,
    output logic        neg
);

    if (!(TESTS_PER_CYCLE == 1 || TESTS_PER_CYCLE == 2 || TESTS_PER_CYCLE == 4 ||
          TESTS_PER_CYCLE == 8 || TESTS_PER_CYCLE == 16)) begin : g_bad_tests_per_cycle
        $error("imm_rot_encoder: TESTS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

`ifdef IMM_NEG_SEARCH_EN
    localparam bit NEG_EN = 1'b1;
`else
    localparam bit NEG_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Rotate left by an even amount 0..30, taken from a doubled copy of the word.
    function automatic logic [31:0] rotl_even(input logic [31:0] v, input logic [3:0] r);
        logic [63:0] w;
        w = {v, v} << {r, 1'b0};
        return w[63:32];
    endfunction

    state_t      state_r, state_s;
    logic [4:0]  rot_cnt_r, rot_cnt_s;
    logic        pass_r, pass_s;
    logic [31:0] value_r, value_s;
    logic [11:0] shift_r, shift_s;
    logic        ok_r, ok_s;
    logic        neg_r, neg_s;
    logic        out_valid_r, out_valid_s;
    logic        in_ready_r, in_ready_s;

    logic [31:0] search_val_s;
    logic [3:0]  cand_rot_s [TESTS_PER_CYCLE];
    logic [31:0] cand_val_s [TESTS_PER_CYCLE];
    logic        hit_s;
    logic [3:0]  hit_rot_s;
    logic [7:0]  hit_imm_s;
    logic        last_group_s;

    // The second pass, when enabled, searches the complemented constant.
    assign search_val_s = pass_r ? ~value_r : value_r;

    // The group never straddles 16 because TESTS_PER_CYCLE divides 16.
    assign last_group_s = ((rot_cnt_r + 5'(TESTS_PER_CYCLE)) == 5'd16);

    for (genvar i = 0; i < TESTS_PER_CYCLE; i++) begin : g_cand
        assign cand_rot_s[i] = rot_cnt_r[3:0] + 4'(i);
        assign cand_val_s[i] = rotl_even(search_val_s, cand_rot_s[i]);
    end

    // Priority pick of the lowest matching candidate in the current group.
    always_comb begin
        hit_s     = 1'b0;
        hit_rot_s = 4'd0;
        hit_imm_s = 8'd0;
        for (int i = 0; i < TESTS_PER_CYCLE; i++) begin
            if (!hit_s && (cand_val_s[i][31:8] == 24'd0)) begin
                hit_s     = 1'b1;
                hit_rot_s = cand_rot_s[i];
                hit_imm_s = cand_val_s[i][7:0];
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/SEARCH/DONE controller.
    always_comb begin
        state_s     = state_r;
        rot_cnt_s   = rot_cnt_r;
        pass_s      = pass_r;
        value_s     = value_r;
        shift_s     = shift_r;
        ok_s        = ok_r;
        neg_s       = neg_r;
        out_valid_s = out_valid_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    value_s   = value;
                    rot_cnt_s = 5'd0;
                    pass_s    = 1'b0;
                    state_s   = ST_SEARCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                if (hit_s) begin
                    shift_s     = {hit_rot_s, hit_imm_s};
                    ok_s        = 1'b1;
                    neg_s       = pass_r;
                    out_valid_s = 1'b1;
                    state_s     = ST_DONE;
                end else if (last_group_s) begin
                    if (NEG_EN && !pass_r) begin
                        pass_s    = 1'b1;
                        rot_cnt_s = 5'd0;
                    end else begin
                        shift_s     = 12'd0;
                        ok_s        = 1'b0;
                        neg_s       = 1'b0;
                        out_valid_s = 1'b1;
                        state_s     = ST_DONE;
                    end
                end else begin
                    rot_cnt_s = rot_cnt_r + 5'(TESTS_PER_CYCLE);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    out_valid_s = 1'b1;
                end
            end
            default: begin
                out_valid_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
        in_ready_s = (state_s == ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            rot_cnt_r   <= 5'd0;
            pass_r      <= 1'b0;
            value_r     <= 32'd0;
            shift_r     <= 12'd0;
            ok_r        <= 1'b0;
            neg_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_s;
            rot_cnt_r   <= rot_cnt_s;
            pass_r      <= pass_s;
            value_r     <= value_s;
            shift_r     <= shift_s;
            ok_r        <= ok_s;
            neg_r       <= neg_s;
            out_valid_r <= out_valid_s;
            in_ready_r  <= in_ready_s;
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_r;
    assign shift_operand = shift_r;
    assign ok            = ok_r;
    assign neg           = neg_r;

endmodule
